// File: rtl/tick_pkg.sv
// Shared constants and helpers for the programmable tick generators.
package tick_pkg;

  // One-second divisors for the common system clocks. The 100 MHz value needs CNT_W >= 27.
  typedef enum int unsigned {
    DIV_1S_50MHZ  = 50_000_000,
    DIV_1S_100MHZ = 100_000_000
  } one_sec_div_e;

  localparam int CNT_W_DEF = 26;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: counter, active/pending divisor pair, one-shot armed flag and registered tick.
module tick_channel
  import tick_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DIV_1S_50MHZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             oneshot_i,
  input  logic             restart_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic [CNT_W-1:0] div_eff;
  logic             armed_q, armed_d;
  logic             tick_q, tick_d;
  logic             busy_q;
  logic             run;
  logic             term;

  assign div_eff = (div_act_q == '0) ? CNT_W'(1) : div_act_q;
  assign run     = en_i & (armed_q | ~oneshot_i);
  // >= rather than == so a divisor shrunk below a held count terminates instead of wrapping.
  assign term    = run & (cnt_q >= (div_eff - CNT_W'(1)));

  always_comb begin
    div_pend_d = wr_i ? div_i : div_pend_q;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    armed_d    = oneshot_i ? armed_q : 1'b1;
    tick_d     = 1'b0;
    if (restart_i) begin
      cnt_d     = '0;
      armed_d   = 1'b1;
      div_act_d = div_pend_d;
    end else if (term) begin
      cnt_d     = '0;
      tick_d    = 1'b1;
      div_act_d = div_pend_d;
      if (oneshot_i) armed_d = 1'b0;
    end else begin
      if (run) cnt_d = cnt_q + CNT_W'(1);
      if (wr_i && !en_i) div_act_d = div_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      div_act_q  <= DIV_RST;
      div_pend_q <= DIV_RST;
      armed_q    <= 1'b1;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      armed_q    <= armed_d;
      tick_q     <= tick_d;
      busy_q     <= run;
    end
  end

  assign tick_o = tick_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/multi_tick_gen.sv
// N-channel programmable tick generator: divisor-write decode in front of independent channels.
module multi_tick_gen
  import tick_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DIV_1S_50MHZ
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH-1:0]            ch_oneshot,
  input  logic [NUM_CH-1:0]            ch_restart,
  input  logic                         cfg_we,
  input  logic [sel_width(NUM_CH)-1:0] cfg_sel,
  input  logic [CNT_W-1:0]             cfg_div,
  output logic [NUM_CH-1:0]            tick,
  output logic [NUM_CH-1:0]            ch_busy
);

  localparam int SEL_W = sel_width(NUM_CH);

  logic [NUM_CH-1:0] wr_sel;

  // Out-of-range selects match no channel and are dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (cfg_sel == SEL_W'(i))) wr_sel[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en_i      (ch_en[g]),
      .oneshot_i (ch_oneshot[g]),
      .restart_i (ch_restart[g]),
      .wr_i      (wr_sel[g]),
      .div_i     (cfg_div),
      .tick_o    (tick[g]),
      .busy_o    (ch_busy[g])
    );
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Scoreboard bench for multi_tick_gen: directed scenarios plus random traffic against a period model.
module tb_multi_tick_gen;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;
  localparam int DEF    = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_en, ch_oneshot, ch_restart;
  logic              cfg_we;
  logic [0:0]        cfg_sel;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] tick, ch_busy;

  always #5 clk = ~clk;

  multi_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .ch_oneshot(ch_oneshot), .ch_restart(ch_restart),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_div(cfg_div), .tick(tick), .ch_busy(ch_busy)
  );

  typedef struct {
    int         due;
    logic [1:0] tick;
    logic [1:0] busy;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   base = 0;
  bit   mark_next = 1'b0;
  int   tick_log[NUM_CH][$];
  int   exp_q[$];

  // Model: each channel tracks cycles elapsed in the current period, the period in force,
  // the period queued for next time, and whether a one-shot has already fired.
  int m_elapsed[NUM_CH];
  int m_period[NUM_CH];
  int m_next[NUM_CH];
  bit m_fired[NUM_CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model(input bit r, input logic [1:0] en, input logic [1:0] os,
                       input logic [1:0] rs, input bit we, input int sel, input int dv,
                       output logic [1:0] et, output logic [1:0] eb);
    int  d, np;
    bit  wr, counting;
    et = '0;
    eb = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r) begin
        m_elapsed[c] = 0;
        m_period[c]  = DEF;
        m_next[c]    = DEF;
        m_fired[c]   = 1'b0;
      end else begin
        d        = (m_period[c] == 0) ? 1 : m_period[c];
        wr       = we && (sel == c);
        np       = wr ? dv : m_next[c];
        counting = en[c] && !(os[c] && m_fired[c]);
        eb[c]    = counting;
        if (rs[c]) begin
          m_elapsed[c] = 0;
          m_fired[c]   = 1'b0;
          m_period[c]  = np;
        end else if (counting && (m_elapsed[c] + 1 >= d)) begin
          et[c]        = 1'b1;
          m_elapsed[c] = 0;
          m_period[c]  = np;
          m_fired[c]   = os[c];
        end else begin
          if (counting) m_elapsed[c] = m_elapsed[c] + 1;
          if (wr && !en[c]) m_period[c] = dv;
          if (!os[c]) m_fired[c] = 1'b0;
        end
        m_next[c] = np;
      end
    end
  endtask

  task automatic step(input bit r, input logic [1:0] en, input logic [1:0] os,
                      input logic [1:0] rs, input bit we, input int sel, input int dv);
    exp_t e;
    @(posedge clk);
    #1;
    if (mark_next) begin
      base = cyc;
      for (int c = 0; c < NUM_CH; c++) tick_log[c].delete();
      mark_next = 1'b0;
    end
    rst        = r;
    ch_en      = en;
    ch_oneshot = os;
    ch_restart = rs;
    cfg_we     = we;
    cfg_sel    = 1'(sel);
    cfg_div    = CNT_W'(dv);
    model(r, en, os, rs, we, sel, dv, e.tick, e.busy);
    e.due = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input int ch);
    bit    ok;
    string got_s, exp_s;
    ok = (tick_log[ch].size() == exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (ok && tick_log[ch][i] != exp_q[i]) ok = 1'b0;
    got_s = "";
    exp_s = "";
    for (int i = 0; i < tick_log[ch].size() && i < 20; i++)
      got_s = {got_s, $sformatf(" %0d", tick_log[ch][i])};
    for (int i = 0; i < exp_q.size(); i++)
      exp_s = {exp_s, $sformatf(" %0d", exp_q[i])};
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: tick cycles [%s ] expected [%s ]", name, got_s, exp_s);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      checks++;
      if (e.due != cyc || tick !== e.tick || ch_busy !== e.busy) begin
        failures++;
        $display("FAIL scoreboard cyc=%0d due=%0d: tick=%b busy=%b expected tick=%b busy=%b",
                 cyc, e.due, tick, ch_busy, e.tick, e.busy);
      end
    end
    for (int c = 0; c < NUM_CH; c++)
      if (tick[c] === 1'b1) tick_log[c].push_back(cyc - base);
  end

  initial begin
    logic [1:0] en, rs, os_r;
    bit         r, we;
    int         sel, dv, idx;

    rst = 1'b1; ch_en = '0; ch_oneshot = '0; ch_restart = '0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_div = '0;

    // Both channels periodic from reset
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    mark_next = 1'b1;
    for (int k = 0; k < 16; k++) step(0, 2'b11, 2'b00, 2'b00, 0, 0, 0);
    settle();
    exp_q = '{5, 10, 15};
    check_log("periodic_ch0", 0);
    check_log("periodic_ch1", 1);

    // Divisor write mid-period: old period completes first
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    mark_next = 1'b1;
    for (int k = 0; k < 17; k++) step(0, 2'b01, 2'b00, 2'b00, (k == 6), 0, 3);
    settle();
    exp_q = '{5, 10, 13, 16};
    check_log("div_write_running", 0);

    // One-shot on ch1, armed out of reset, restarts take effect on the edges into 20 and 61
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    mark_next = 1'b1;
    for (int k = 0; k < 71; k++)
      step(0, 2'b10, 2'b10, (k == 19 || k == 60) ? 2'b10 : 2'b00, 0, 0, 0);
    settle();
    exp_q = '{5, 25, 66};
    check_log("oneshot_ch1", 1);

    // Enable gap holds the count
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b00, 2'b00, 2'b00, 1, 0, 4);
    mark_next = 1'b1;
    for (int k = 0; k < 10; k++)
      step(0, (k >= 2 && k <= 4) ? 2'b00 : 2'b01, 2'b00, 2'b00, 0, 0, 0);
    settle();
    exp_q = '{7};
    check_log("enable_gap", 0);

    // Restart coinciding with terminal count suppresses the tick
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    mark_next = 1'b1;
    for (int k = 0; k < 16; k++) step(0, 2'b01, 2'b00, (k == 4) ? 2'b01 : 2'b00, 0, 0, 0);
    settle();
    exp_q = '{10, 15};
    check_log("restart_on_terminal", 0);

    // Divisor 0 behaves as 1
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    mark_next = 1'b1;
    for (int k = 0; k < 9; k++) step(0, 2'b10, 2'b00, 2'b00, 0, 0, 0);
    settle();
    exp_q = '{1, 2, 3, 4, 5, 6, 7, 8};
    check_log("div_zero", 1);

    // Reset mid-count drops the pending divisor and restarts the phase
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    mark_next = 1'b1;
    for (int k = 0; k < 16; k++) step((k == 7), 2'b11, 2'b00, 2'b00, (k == 1), 0, 3);
    settle();
    exp_q = '{5, 13};
    check_log("reset_mid_count_ch0", 0);
    check_log("reset_mid_count_ch1", 1);

    // Random traffic
    os_r = 2'b00;
    for (int k = 0; k < 2000; k++) begin
      r  = ($urandom_range(0, 299) == 0);
      en = {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)};
      if ($urandom_range(0, 39) == 0) begin
        idx = $urandom_range(0, 1);
        os_r[idx] = ~os_r[idx];
      end
      rs  = {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0)};
      we  = ($urandom_range(0, 5) == 0);
      sel = $urandom_range(0, 1);
      dv  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 12);
      step(r, en, os_r, rs, we, sel, dv);
    end

    @(posedge clk);
    settle();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
